// File: rtl/execute_result_stage.sv
// Execute result stage: writeback skid buffer, branch/jump resolution and wrong-path kill.
// Optional macro BRANCH_STATS_EN adds stat_branches / stat_taken counters.
module execute_result_stage #(
  parameter int XLEN = 32,
  parameter int RA_W = 5
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_result,
  input  logic            in_cond,
  input  logic [RA_W-1:0] in_rd,
  input  logic            in_wr_en,
  input  logic            in_branch,
  input  logic            in_jal,
  input  logic            in_jalr,
  input  logic [XLEN-1:0] in_pc,
  input  logic [XLEN-1:0] in_imm,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_data,
  output logic [RA_W-1:0] out_rd,
  output logic            out_wr_en,
  output logic            redirect_valid,
  output logic [XLEN-1:0] redirect_pc
`ifdef BRANCH_STATS_EN
  ,
  output logic [31:0]     stat_branches,
  output logic [31:0]     stat_taken
`endif
);

  logic [XLEN-1:0] r_d0, r_d1;
  logic [RA_W-1:0] r_rd0, r_rd1;
  logic            r_we0, r_we1, r_v0, r_v1;
  logic            r_kill, r_in_ready, r_redir_v;
  logic [XLEN-1:0] r_redir_pc;

  logic            w_accept, w_push, w_pop, w_taken, w_we;
  logic [XLEN-1:0] w_data, w_target;
  logic [XLEN-1:0] w_n_d0, w_n_d1;
  logic [RA_W-1:0] w_n_rd0, w_n_rd1;
  logic            w_n_we0, w_n_we1, w_n_v0, w_n_v1;

  assign w_accept = in_valid && r_in_ready;
  assign w_push   = w_accept && !r_kill;
  assign w_pop    = r_v0 && out_ready;
  assign w_taken  = in_jal || in_jalr || (in_branch && in_cond);
  assign w_we     = in_wr_en && (in_rd != {RA_W{1'b0}}) && !in_branch;
  assign w_data   = (in_jal || in_jalr) ? (in_pc + XLEN'(4)) : in_result;
  assign w_target = in_jalr ? (in_result & {{(XLEN-1){1'b1}}, 1'b0}) : (in_pc + in_imm);

  // Pop shifts the tail into the head; a push then fills the first free slot.
  always_comb begin
    w_n_d0 = r_d0; w_n_rd0 = r_rd0; w_n_we0 = r_we0; w_n_v0 = r_v0;
    w_n_d1 = r_d1; w_n_rd1 = r_rd1; w_n_we1 = r_we1; w_n_v1 = r_v1;
    if (w_pop) begin
      w_n_d0 = r_d1; w_n_rd0 = r_rd1; w_n_we0 = r_we1; w_n_v0 = r_v1;
      w_n_v1 = 1'b0;
    end else begin
      w_n_v1 = r_v1;
    end
    if (w_push && !w_n_v0) begin
      w_n_d0 = w_data; w_n_rd0 = in_rd; w_n_we0 = w_we; w_n_v0 = 1'b1;
    end else if (w_push) begin
      w_n_d1 = w_data; w_n_rd1 = in_rd; w_n_we1 = w_we; w_n_v1 = 1'b1;
    end else begin
      w_n_v0 = w_n_v0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_d0       <= {XLEN{1'b0}};
      r_d1       <= {XLEN{1'b0}};
      r_rd0      <= {RA_W{1'b0}};
      r_rd1      <= {RA_W{1'b0}};
      r_we0      <= 1'b0;
      r_we1      <= 1'b0;
      r_v0       <= 1'b0;
      r_v1       <= 1'b0;
      r_kill     <= 1'b0;
      r_in_ready <= 1'b1;
      r_redir_v  <= 1'b0;
      r_redir_pc <= {XLEN{1'b0}};
    end else begin
      r_d0       <= w_n_d0;
      r_d1       <= w_n_d1;
      r_rd0      <= w_n_rd0;
      r_rd1      <= w_n_rd1;
      r_we0      <= w_n_we0;
      r_we1      <= w_n_we1;
      r_v0       <= w_n_v0;
      r_v1       <= w_n_v1;
      r_in_ready <= !(w_n_v0 && w_n_v1);
      r_redir_v  <= w_push && w_taken;
      // A killed instruction clears the flag; a surviving redirect arms it.
      if (w_accept && r_kill) begin
        r_kill <= 1'b0;
      end else if (w_push && w_taken) begin
        r_kill     <= 1'b1;
        r_redir_pc <= w_target;
      end else begin
        r_kill <= r_kill;
      end
    end
  end

`ifdef BRANCH_STATS_EN
  logic [31:0] r_stat_br, r_stat_tk;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_stat_br <= 32'd0;
      r_stat_tk <= 32'd0;
    end else if (w_push && in_branch) begin
      r_stat_br <= r_stat_br + 32'd1;
      r_stat_tk <= r_stat_tk + {31'd0, in_cond};
    end else begin
      r_stat_br <= r_stat_br;
      r_stat_tk <= r_stat_tk;
    end
  end

  assign stat_branches = r_stat_br;
  assign stat_taken    = r_stat_tk;
`endif

  assign in_ready       = r_in_ready;
  assign out_valid      = r_v0;
  assign out_data       = r_d0;
  assign out_rd         = r_rd0;
  assign out_wr_en      = r_we0;
  assign redirect_valid = r_redir_v;
  assign redirect_pc    = r_redir_pc;

endmodule

// File: tb/tb_execute_result_stage.sv
// Directed bench for execute_result_stage with hand-computed expectations.
module tb_execute_result_stage;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0, in_ready;
  logic [31:0] in_result = 32'd0, in_pc = 32'd0, in_imm = 32'd0;
  logic        in_cond = 1'b0, in_wr_en = 1'b0, in_branch = 1'b0, in_jal = 1'b0, in_jalr = 1'b0;
  logic [4:0]  in_rd = 5'd0;
  logic        out_valid, out_ready = 1'b0, out_wr_en, redirect_valid;
  logic [31:0] out_data, redirect_pc;
  logic [4:0]  out_rd;
`ifdef BRANCH_STATS_EN
  logic [31:0] stat_branches, stat_taken;
`endif
  int n_chk = 0;
  int n_fail = 0;

  execute_result_stage dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_result(in_result), .in_cond(in_cond), .in_rd(in_rd), .in_wr_en(in_wr_en),
    .in_branch(in_branch), .in_jal(in_jal), .in_jalr(in_jalr), .in_pc(in_pc), .in_imm(in_imm),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_rd(out_rd),
    .out_wr_en(out_wr_en), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
`ifdef BRANCH_STATS_EN
    , .stat_branches(stat_branches), .stat_taken(stat_taken)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic ins(input logic v, input logic [31:0] res, input logic [4:0] rd, input logic we,
                     input logic br, input logic cond, input logic jal, input logic jalr,
                     input logic [31:0] pc, input logic [31:0] imm);
    in_valid = v; in_result = res; in_rd = rd; in_wr_en = we; in_branch = br;
    in_cond = cond; in_jal = jal; in_jalr = jalr; in_pc = pc; in_imm = imm;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    step(); step();
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_data", out_data, 32'd0);
    check("rst_out_rd", {27'd0, out_rd}, 32'd0);
    check("rst_out_wr_en", {31'd0, out_wr_en}, 32'd0);
    check("rst_redir_valid", {31'd0, redirect_valid}, 32'd0);
    check("rst_redir_pc", redirect_pc, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    reset = 1'b0;

    // plain write
    out_ready = 1'b1;
    ins(1'b1, 32'h2A, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h100, 32'd0);
    step();
    check("add_valid", {31'd0, out_valid}, 32'd1);
    check("add_data", out_data, 32'h2A);
    check("add_rd", {27'd0, out_rd}, 32'd5);
    check("add_we", {31'd0, out_wr_en}, 32'd1);
    check("add_noredir", {31'd0, redirect_valid}, 32'd0);
    ins(1'b0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'd0);
    step();
    check("add_drained", {31'd0, out_valid}, 32'd0);

    // backpressure
    out_ready = 1'b0;
    ins(1'b1, 32'h11, 5'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h104, 32'd0);
    step();
    check("bp_ready1", {31'd0, in_ready}, 32'd1);
    ins(1'b1, 32'h22, 5'd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h108, 32'd0);
    step();
    check("bp_ready2", {31'd0, in_ready}, 32'd0);
    ins(1'b1, 32'h33, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h10C, 32'd0);
    step();
    check("bp_full_ready", {31'd0, in_ready}, 32'd0);
    check("bp_hold_data", out_data, 32'h11);
    out_ready = 1'b1;
    step();
    check("bp_second", out_data, 32'h22);
    check("bp_ready_again", {31'd0, in_ready}, 32'd1);
    step();
    check("bp_third", out_data, 32'h33);
    check("bp_third_rd", {27'd0, out_rd}, 32'd3);
    ins(1'b0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'd0);
    step();
    check("bp_empty", {31'd0, out_valid}, 32'd0);

    // taken branch then killed add
    ins(1'b1, 32'h5, 5'd7, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h200, 32'hFFFFFFF0);
    step();
    check("br_redir_v", {31'd0, redirect_valid}, 32'd1);
    check("br_redir_pc", redirect_pc, 32'h1F0);
    check("br_valid", {31'd0, out_valid}, 32'd1);
    check("br_we", {31'd0, out_wr_en}, 32'd0);
    ins(1'b1, 32'h77, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h204, 32'd0);
    step();
    check("kill_valid", {31'd0, out_valid}, 32'd0);
    check("kill_redir_v", {31'd0, redirect_valid}, 32'd0);
`ifdef BRANCH_STATS_EN
    check("stat_br", stat_branches, 32'd1);
    check("stat_tk", stat_taken, 32'd1);
`endif

    // not-taken branch does not kill the next instruction
    ins(1'b1, 32'h0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h200, 32'h40);
    step();
    check("nt_redir_v", {31'd0, redirect_valid}, 32'd0);
    check("nt_valid", {31'd0, out_valid}, 32'd1);
    ins(1'b1, 32'h99, 5'd4, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h204, 32'd0);
    step();
    check("nt_next_data", out_data, 32'h99);
    check("nt_next_we", {31'd0, out_wr_en}, 32'd1);

    // jalr, then a filler that gets killed
    ins(1'b1, 32'h301, 5'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h400, 32'h0);
    step();
    check("jalr_redir_v", {31'd0, redirect_valid}, 32'd1);
    check("jalr_redir_pc", redirect_pc, 32'h300);
    check("jalr_data", out_data, 32'h404);
    check("jalr_we", {31'd0, out_wr_en}, 32'd1);
    ins(1'b1, 32'hDEAD, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h404, 32'h0);
    step();
    check("jalr_kill", {31'd0, out_valid}, 32'd0);

    // rd=0 and wrapping jal
    ins(1'b1, 32'h55, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h500, 32'h0);
    step();
    check("rd0_we", {31'd0, out_wr_en}, 32'd0);
    check("rd0_data", out_data, 32'h55);
    ins(1'b1, 32'h0, 5'd1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'hFFFFFFFC, 32'h8);
    step();
    check("jal_redir_pc", redirect_pc, 32'h4);
    check("jal_data", out_data, 32'h0);
    check("jal_we", {31'd0, out_wr_en}, 32'd1);
    ins(1'b1, 32'hBEEF, 5'd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    step();
    check("jal_kill", {31'd0, out_valid}, 32'd0);

    // reset mid-operation with a pending redirect
    out_ready = 1'b0;
    ins(1'b1, 32'h12, 5'd6, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h600, 32'h0);
    step();
    ins(1'b1, 32'h0, 5'd1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h604, 32'h20);
    step();
    check("pre_rst_redir", {31'd0, redirect_valid}, 32'd1);
    ins(1'b0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'd0);
    #2 reset = 1'b1;
    #1;
    check("arst_valid", {31'd0, out_valid}, 32'd0);
    check("arst_redir_v", {31'd0, redirect_valid}, 32'd0);
    reset = 1'b0;
    #1;
    check("arst_ready", {31'd0, in_ready}, 32'd1);
    out_ready = 1'b1;
    ins(1'b1, 32'h66, 5'd6, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h700, 32'h0);
    step();
    check("arst_nokill", {31'd0, out_valid}, 32'd1);
    check("arst_data", out_data, 32'h66);
    ins(1'b0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'd0);
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/execute_result_stage.md
Name: execute_result_stage

Overview:
- Pipeline stage directly downstream of the arithmetic logic unit.
- Captures the primary result and secondary compare bit, resolves branches and jumps, and computes the redirect target.
- Presents writeback data to the register-file stage through a 2-entry skid buffer with valid/ready handshakes on both sides.
- Squashes the single wrong-path instruction that follows a taken redirect.

Parameters:
- XLEN, 32, datapath width (result, pc, imm).
- RA_W, 5, register address width.

Ports:
- clk  input  1  clock; all state on rising edge.
- reset  input  1  asynchronous, active-high reset.
- in_valid  input  1  upstream holds a valid ALU result.
- in_ready  output  1  stage can accept; transfer when in_valid && in_ready.
- in_result  input  XLEN  ALU primary output.
- in_cond  input  1  ALU secondary compare output.
- in_rd  input  RA_W  destination register.
- in_wr_en  input  1  instruction writes rd.
- in_branch  input  1  conditional branch.
- in_jal  input  1  pc-relative jump.
- in_jalr  input  1  register-indirect jump.
- in_pc  input  XLEN  instruction address.
- in_imm  input  XLEN  sign-extended immediate.
- out_valid  output  1  writeback entry available.
- out_ready  input  1  downstream accepts; transfer when out_valid && out_ready.
- out_data  output  XLEN  writeback value.
- out_rd  output  RA_W  writeback register.
- out_wr_en  output  1  write enable; 0 when rd == 0.
- redirect_valid  output  1  one-cycle fetch redirect pulse.
- redirect_pc  output  XLEN  redirect target.

Behaviour:
- Reset (async, immediate): both buffer entries invalid; kill flag 0; out_valid = 0, out_data = 0, out_rd = 0, out_wr_en = 0, redirect_valid = 0, redirect_pc = 0, in_ready = 1.
- Storage: 2-entry FIFO, head entry drives the out_* ports.
- Occupancy states:
  - EMPTY -> ONE on accept.
  - ONE -> TWO on accept without pop.
  - TWO -> ONE on pop.
  - ONE -> EMPTY on pop without accept.
  - Simultaneous accept and pop in ONE stays ONE, with the new entry becoming head.
- in_ready = (occupancy != TWO). Registered, so it depends only on state, never on out_ready.
- Latency: an accepted instruction appears on out_valid at the next edge at the earliest.
- Write data:
  - in_jal or in_jalr: out_data = in_pc + 4.
  - Otherwise: out_data = in_result.
- out_wr_en = in_wr_en && (in_rd != 0) && !in_branch.
- Branches enter the buffer with out_wr_en = 0. They are still popped normally so retirement order is preserved.
- Redirect taken when:
  - in_jal, or
  - in_jalr, or
  - in_branch && in_cond.
- Redirect target:
  - in_jalr: redirect_pc = (in_result) & ~1. The ALU computes rs1+imm.
  - Otherwise: redirect_pc = in_pc + in_imm.
  - All adds wrap modulo 2^XLEN.
- On accept of a redirecting instruction:
  - redirect_valid = 1 for exactly the next cycle, with redirect_pc registered.
  - The kill flag is set.
- Kill flag: the next accepted instruction is consumed, but not written into the buffer, not redirected, and not counted. The flag then clears.
- If the accept stalls because in_ready = 0, the kill flag persists until an accept occurs.
- A not-taken branch produces no redirect and no kill.
- Back-to-back redirects are impossible: the second instruction is always killed.
- Stall while full: held entries and out_* values are stable until popped.

Optional Feature:
- Macro: BRANCH_STATS_EN.
- When defined, adds output ports:
  - stat_branches (32): count of non-killed accepted in_branch instructions.
  - stat_taken (32): count of those with in_cond = 1.
- Both counters wrap at 2^32 and reset to 0.
- Killed instructions are never counted.
- When undefined, the ports and counters are absent and behaviour is otherwise identical.

Test Plan:
- Plain writes: add pc=0x100, result 0x2A, rd=5, out_ready=1 -> next cycle out_valid=1, out_data=0x2A, out_rd=5, out_wr_en=1, no redirect.
- Backpressure: 3 instructions back-to-back with out_ready=0:
  - in_ready drops after 2 accepts; third is held upstream.
  - Raise out_ready -> outputs appear in order, no loss or duplication.
- Taken branch: pc=0x200, imm=0xFFFFFFF0, cond=1, followed by add rd=3:
  - redirect_valid pulses once with redirect_pc=0x1F0.
  - Add is killed: never appears, out_wr_en=0 for the branch.
  - Stats (if enabled) branches=1, taken=1.
- Jalr: result 0x301, pc=0x400, rd=1 -> redirect_pc=0x300, out_data=0x404, out_wr_en=1.
- rd=0 and wrap: rd=0 write -> out_wr_en=0. jal pc=0xFFFFFFFC, imm=8 -> redirect_pc=0x4, out_data=0x0.
- Reset mid-operation: fill 2 entries, assert reset asynchronously between edges -> out_valid=0 and redirect_valid=0 immediately; in_ready=1 and kill flag clear after release.
